wb_cpu_master: RTL and testbench
================================

Name: wb_cpu_master

Overview:
- Bridges the CPU load/store port onto the 16-bit Wishbone bus. It sits directly upstream of the Wishbone bus interface and drives its adr/data/we/sel/cyc/stb lines.
- Accepts CPU requests through a valid/ready handshake and buffers them in a small request FIFO.
- Runs one classic single-beat Wishbone cycle per request and returns read data / completion to the CPU.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- SEL_W, 4, byte-select width (passed through unchanged)
- FIFO_DEPTH, 2, request buffer entries (power of two, ≥2)
- TIMEOUT_CYC, 255, bus cycles before abort (only with optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  request accepted this cycle when req_valid is high
- req_we  in  1  0 = read, 1 = write
- req_adr  in  ADDR_W  request address
- req_data  in  DATA_W  write data
- req_sel  in  SEL_W  byte selects
- rsp_valid  out  1  one-cycle pulse, request completed
- rsp_data  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  completion was a timeout abort
- adr_out  out  ADDR_W  Wishbone address
- data_out  out  DATA_W  Wishbone write data
- data_in  in  DATA_W  Wishbone read data
- we  out  1  Wishbone write enable, low = read, high = write
- sel_out  out  SEL_W  Wishbone selects
- cyc_out  out  1  Wishbone cycle
- stb_out  out  1  Wishbone strobe
- ack_in  in  1  Wishbone acknowledge

Behaviour:
- Reset (async, active-high), all outputs 0:
  - FIFO empty; FSM in IDLE.
  - cyc_out, stb_out, we, adr_out, data_out, sel_out = 0.
  - rsp_valid, rsp_err, rsp_data = 0.
  - req_ready = 0 while reset is asserted, 1 after reset is released.
- Request FIFO:
  - req_ready = !full.
  - Push on req_valid && req_ready.
  - Pop when the FSM leaves BUS.
  - Push and pop in the same cycle while full is legal: count is unchanged, and req_ready stays 0 that cycle because it is based on registered full.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE:
  - If FIFO is not empty, register the head entry onto adr_out/data_out/we/sel_out.
  - Assert cyc_out = stb_out = 1 and go to BUS. The bus starts 1 cycle after the entry is visible in the FIFO.
  - A push into an empty FIFO reaches the bus 2 cycles after the handshake.
- FSM BUS:
  - Hold all bus outputs stable until ack_in is sampled high.
  - On ack_in: drop cyc_out/stb_out next cycle and pop the FIFO.
  - Assert rsp_valid for 1 cycle, with rsp_data = data_in captured on the ack cycle for reads, or 0 for writes. rsp_err = 0.
  - Go to IDLE.
- Back-to-back requests: minimum 1 idle cycle with cyc_out = 0 between consecutive bus cycles.
- ack_in while cyc_out = 0: ignored, no response.
- data_out and we hold their values after a cycle ends. Only cyc_out/stb_out qualify the bus.
- Mid-operation reset: the bus cycle is abandoned immediately, FIFO contents are discarded, and no response is produced.
- rsp_valid has no backpressure; the CPU must always accept it.

Optional Feature:
- Macro: WB_CPU_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter (sized by TIMEOUT_CYC) clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYC with no ack, drop cyc_out/stb_out and pop the FIFO.
  - Pulse rsp_valid with rsp_err = 1 and rsp_data = 0.
  - An ack on the same cycle as the timeout takes priority: normal completion.
- Undefined: no counter; BUS waits indefinitely; rsp_err is tied to 0.

Decomposition:
- Shared package wb_pkg holds:
  - WB_ADDR_W = 16, WB_DATA_W = 16, WB_SEL_W = 4.
  - Typedef wb_req_t, a packed struct {we, adr, data, sel}.
  - Enum wb_mst_state_e {IDLE, BUS}.
- One natural sub-module: wb_req_fifo, a parameterised synchronous FIFO of wb_req_t with full/empty outputs, instantiated once.

Test Plan:
- Single write:
  - Stimulus: req adr = 16'h0010, data = 16'hBEEF, sel = 4'hF, slave acks 1 cycle after stb.
  - Required: cyc/stb high exactly 2 cycles with we = 1 and adr/data stable, then rsp_valid pulse with rsp_data = 0.
- Single read:
  - Stimulus: adr = 16'h0020, slave returns data_in = 16'h1234 with a 3-cycle wait.
  - Required: rsp_valid 1 cycle after ack, rsp_data = 16'h1234, rsp_err = 0.
- FIFO full:
  - Stimulus: 3 requests pushed on consecutive cycles while the slave stalls ack.
  - Required: req_ready low after 2 accepted; third accepted after the first ack; 3 responses in order.
- Reset mid-cycle:
  - Stimulus: assert reset while cyc_out = 1 with 1 entry queued.
  - Required: cyc_out/stb_out drop asynchronously, no rsp_valid, FIFO empty after release.
- Spurious ack:
  - Stimulus: ack_in pulsed while idle.
  - Required: no rsp_valid and no state change.
- Timeout (WB_CPU_MASTER_TIMEOUT_EN, TIMEOUT_CYC = 8):
  - Stimulus: slave never acks.
  - Required: cyc drops after 8 BUS cycles; rsp_valid with rsp_err = 1 and rsp_data = 0; the next queued request then proceeds normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, the buffered CPU request record
// and the master FSM state type.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 16;
  localparam int unsigned WB_DATA_W = 16;
  localparam int unsigned WB_SEL_W  = 4;

  // One buffered CPU request, exactly what the bus cycle needs.
  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] data;
    logic [WB_SEL_W-1:0]  sel;
  } wb_req_t;

  typedef enum logic {
    IDLE,
    BUS
  } wb_mst_state_e;

endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous request FIFO of wb_req_t. DEPTH must be a power of two so the
// pointers wrap naturally. Full/empty come straight from the registered count.
module wb_req_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  wb_req_t i_wdata,
  input  logic    i_pop,
  output wb_req_t o_rdata,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  // A simultaneous pop frees the slot being written, so push-while-full is safe.
  assign w_push = i_push && (!w_full || w_pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_cpu_master.sv
// CPU load/store to Wishbone bridge. Requests are buffered in wb_req_fifo and
// each one runs a single-beat classic Wishbone cycle, answered by a one-cycle
// rsp_valid pulse. Define WB_CPU_MASTER_TIMEOUT_EN to abort cycles that see no
// ack within TIMEOUT_CYC bus cycles (reported with rsp_err = 1).
module wb_cpu_master
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W      = WB_ADDR_W,
  parameter int unsigned DATA_W      = WB_DATA_W,
  parameter int unsigned SEL_W       = WB_SEL_W,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] adr_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              we,
  output logic [SEL_W-1:0]  sel_out,
  output logic              cyc_out,
  output logic              stb_out,
  input  logic              ack_in
);

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_cpu_master: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("wb_cpu_master: TIMEOUT_CYC must be non-zero");
  end

  wb_mst_state_e     r_state;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_sel;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  wb_req_t w_push_req;
  wb_req_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  logic    w_to_hit;

  // Ready is held low throughout reset, otherwise it tracks the registered full flag.
  assign req_ready  = !w_full && !reset;
  assign w_push     = req_valid && req_ready;
  assign w_push_req = '{we: req_we, adr: req_adr, data: req_data, sel: req_sel};
  // The head entry stays queued for the whole bus cycle and leaves as BUS exits.
  assign w_pop      = (r_state == BUS) && (ack_in || w_to_hit);

  wb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_wdata (w_push_req),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef WB_CPU_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TO_W-1:0] r_to_cnt;

  // Count unacked BUS cycles; held at zero outside BUS so every cycle starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state != BUS) begin
      r_to_cnt <= '0;
    end else if (!ack_in) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_to_hit = (r_state == BUS) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  // Master FSM: launch the FIFO head, wait for ack (or timeout), respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_data      <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_we    <= w_head.we;
            r_adr   <= w_head.adr;
            r_data  <= w_head.data;
            r_sel   <= w_head.sel;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= BUS;
          end
        end
        BUS: begin
          // Ack wins over a timeout landing on the same cycle.
          if (ack_in) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_we ? '0 : data_in;
            r_state     <= IDLE;
          end else if (w_to_hit) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cyc_out   = r_cyc;
  assign stb_out   = r_stb;
  assign we        = r_we;
  assign adr_out   = r_adr;
  assign data_out  = r_data;
  assign sel_out   = r_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_wb_cpu_master.sv
// Bench for wb_cpu_master: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model (request queue, bus
// busy flag, expected response).
module tb_wb_cpu_master;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TO    = 8;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [15:0] data;
    logic [3:0]  sel;
  } m_req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_adr, req_data;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic [15:0] adr_out, data_out, data_in;
  logic        we;
  logic [3:0]  sel_out;
  logic        cyc_out, stb_out, ack_in;

  always #5 clk = ~clk;

  wb_cpu_master #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .SEL_W       (4),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_data  (req_data),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .adr_out   (adr_out),
    .data_out  (data_out),
    .data_in   (data_in),
    .we        (we),
    .sel_out   (sel_out),
    .cyc_out   (cyc_out),
    .stb_out   (stb_out),
    .ack_in    (ack_in)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state: accepted-but-unfinished requests (head is on the bus when busy).
  m_req_t      m_q[$];
  logic        m_busy;
  m_req_t      m_last;
  logic        m_rsp_due;
  logic        m_rsp_err;
  logic [15:0] m_rsp_data;
  int          m_wait;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy     = 1'b0;
    m_last     = '0;
    m_rsp_due  = 1'b0;
    m_rsp_err  = 1'b0;
    m_rsp_data = '0;
    m_wait     = 0;
  endtask

  task automatic check_outputs();
    chk("cyc", 32'(cyc_out), 32'(m_busy));
    chk("stb", 32'(stb_out), 32'(m_busy));
    chk("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
    chk("adr_out", 32'(adr_out), 32'(m_last.adr));
    chk("data_out", 32'(data_out), 32'(m_last.data));
    chk("we", 32'(we), 32'(m_last.we));
    chk("sel_out", 32'(sel_out), 32'(m_last.sel));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_due));
    if (m_rsp_due) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
      chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
    end
  endtask

  // One clock: check current outputs, drive inputs, advance model, step clock.
  task automatic cycle(input logic v, input m_req_t r, input logic ack, input logic [15:0] din,
                       output logic acc);
    check_outputs();
    req_valid = v;
    req_we    = r.we;
    req_adr   = r.adr;
    req_data  = r.data;
    req_sel   = r.sel;
    ack_in    = ack;
    data_in   = din;
    acc = v && (m_q.size() < DEPTH);
    m_rsp_due  = 1'b0;
    m_rsp_err  = 1'b0;
    m_rsp_data = '0;
    if (m_busy) begin
      if (ack) begin
        m_rsp_due  = 1'b1;
        m_rsp_data = m_q[0].we ? 16'h0 : din;
        m_q.delete(0);
        m_busy = 1'b0;
      end else begin
        m_wait++;
`ifdef WB_CPU_MASTER_TIMEOUT_EN
        if (m_wait == TO) begin
          m_rsp_due = 1'b1;
          m_rsp_err = 1'b1;
          m_q.delete(0);
          m_busy = 1'b0;
        end
`endif
      end
    end else if (m_q.size() != 0) begin
      m_busy = 1'b1;
      m_wait = 0;
      m_last = m_q[0];
    end
    if (acc) m_q.push_back(r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic ack);
    logic dummy;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, ack, 16'($urandom), dummy);
  endtask

  // Idle CPU side with a slave that acks whenever the model says a cycle is live.
  task automatic drain(input int n);
    logic dummy;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, m_busy, 16'($urandom), dummy);
  endtask

  task automatic reset_checks();
    chk("rst_cyc", 32'(cyc_out), 32'd0);
    chk("rst_stb", 32'(stb_out), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_adr", 32'(adr_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
  endtask

  initial begin
    m_req_t r, r0, r1, r2;
    logic   acc;
    logic   pend;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_data  = '0;
    req_sel   = '0;
    ack_in    = 1'b0;
    data_in   = '0;
    model_clear();
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Single write, slave acks on the second bus cycle.
    r = '{we: 1'b1, adr: 16'h0010, data: 16'hBEEF, sel: 4'hF};
    cycle(1'b1, r, 1'b0, 16'h0, acc);
    chk("write_accepted", 32'(acc), 32'd1);
    run(2, 1'b0);
    run(1, 1'b1);
    run(2, 1'b0);

    // Single read with three wait states.
    r = '{we: 1'b0, adr: 16'h0020, data: 16'h5555, sel: 4'h3};
    cycle(1'b1, r, 1'b0, 16'h0, acc);
    run(4, 1'b0);
    cycle(1'b0, r, 1'b1, 16'h1234, acc);
    run(2, 1'b0);

    // Spurious acks while idle.
    run(3, 1'b1);
    run(1, 1'b0);

    // FIFO full: third request waits until the first cycle is acked.
    r0 = '{we: 1'b0, adr: 16'h0100, data: 16'h0, sel: 4'h1};
    r1 = '{we: 1'b1, adr: 16'h0102, data: 16'hCAFE, sel: 4'h2};
    r2 = '{we: 1'b0, adr: 16'h0104, data: 16'h0, sel: 4'h4};
    cycle(1'b1, r0, 1'b0, 16'h0, acc);
    cycle(1'b1, r1, 1'b0, 16'h0, acc);
    cycle(1'b1, r2, 1'b0, 16'h0, acc);
    chk("full_blocks_third", 32'(req_ready), 32'd0);
    cycle(1'b1, r2, 1'b0, 16'h0, acc);
    cycle(1'b1, r2, 1'b1, 16'hA0A0, acc);
    cycle(1'b1, r2, 1'b0, 16'h0, acc);
    chk("third_accepted", 32'(acc), 32'd1);
    drain(20);

    // Reset while a cycle is live and another request is queued.
    cycle(1'b1, r0, 1'b0, 16'h0, acc);
    cycle(1'b1, r1, 1'b0, 16'h0, acc);
    check_outputs();
    reset = 1'b1;
    #1;
    chk("midrst_cyc", 32'(cyc_out), 32'd0);
    chk("midrst_stb", 32'(stb_out), 32'd0);
    chk("midrst_rsp", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    run(4, 1'b1);

`ifdef WB_CPU_MASTER_TIMEOUT_EN
    // Slave never acks the first request; the second proceeds after the abort.
    cycle(1'b1, r0, 1'b0, 16'h0, acc);
    cycle(1'b1, r1, 1'b0, 16'h0, acc);
    run(12, 1'b0);
    drain(6);
`endif

    // Random traffic with random wait states and occasional spurious acks.
    pend = 1'b0;
    r    = '0;
    for (int i = 0; i < 800; i++) begin
      logic ack;
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        r.we   = 1'($urandom_range(0, 1));
        r.adr  = 16'($urandom);
        r.data = 16'($urandom);
        r.sel  = 4'($urandom);
        pend   = 1'b1;
      end
      ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cycle(pend, r, ack, 16'($urandom), acc);
      if (acc) pend = 1'b0;
    end
    drain(30);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
